// File: rtl/mpc_mac_acc_sat_if.sv
// Operand-tag / product / result bundle for mpc_mac_acc_sat.
// The slave modport is the accumulator side; master is the upstream/consumer side.
interface mpc_mac_acc_sat_if #(
  parameter int PROD_WIDTH = 35,
  parameter int OUT_WIDTH  = 21
);
  logic                         in_valid;
  logic                         in_first;
  logic                         in_last;
  logic signed [PROD_WIDTH-1:0] prod;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         seq_err;
  logic                         len_err;
  logic                         ovr_err;
  logic [15:0]                  sat_count;

  modport master (
    output in_valid, in_first, in_last, prod, out_ready,
    input  out_valid, out_data, seq_err, len_err, ovr_err, sat_count
  );

  modport slave (
    input  in_valid, in_first, in_last, prod, out_ready,
    output out_valid, out_data, seq_err, len_err, ovr_err, sat_count
  );
endinterface

// File: rtl/mpc_mac_acc_sat.sv
// Framed saturating accumulator behind the MPC multiplier: tag delay line, dot-product sum, round/rescale/saturate.
// Optional saturation event counter built only when MPC_MAC_SAT_CNT_EN is defined.
module mpc_mac_acc_sat #(
  parameter int MUL_LATENCY = 3,
  parameter int PROD_WIDTH  = 35,
  parameter int ACC_WIDTH   = 40,
  parameter int SHIFT       = 13,
  parameter int OUT_WIDTH   = 21,
  parameter int MAX_TERMS   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  mpc_mac_acc_sat_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_TERMS + 2);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0]   RND_HALF  = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0]   OUT_MAX_W = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0]   OUT_MIN_W = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN   = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t state_reg, state_next;

  logic [2:0]                   tag_in;
  logic                         v_a, f_a, l_a;
  logic                         beat;
  logic                         take_first, take_add, take_last, seq_hit, len_hit;
  logic signed [ACC_WIDTH-1:0]  acc_reg, acc_next, prod_ext, sum_sat;
  logic signed [ACC_WIDTH:0]    sum_wide, rnd_wide, rnd_shift;
  logic                         acc_clamp, out_hi, out_lo;
  logic signed [OUT_WIDTH-1:0]  result_next, out_data_reg;
  logic                         out_valid_reg;
  logic                         seq_err_reg, len_err_reg, ovr_err_reg;
  logic [CNT_W-1:0]             cnt_reg;

  // Tags ride a ce-gated delay line matching the multiplier depth, so the tail lines up with prod.
  assign tag_in = {bus.in_valid, bus.in_first, bus.in_last};

  generate
    for (genvar gi = 0; gi < MUL_LATENCY; gi++) begin : g_tag
      logic [2:0] tag_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset)   tag_reg <= '0;
          else if (ce) tag_reg <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (reset)   tag_reg <= '0;
          else if (ce) tag_reg <= g_tag[gi-1].tag_reg;
        end
      end
    end
  endgenerate

  assign {v_a, f_a, l_a} = g_tag[MUL_LATENCY-1].tag_reg;
  assign beat = ce & v_a;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (beat) begin
      case (state_reg)
        IDLE:    if (f_a && !l_a) state_next = ACCUM;
        ACCUM:   if (l_a)         state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A first tag always restarts the sum; in ACCUM it also flags the broken frame.
  always_comb begin
    take_first = 1'b0;
    take_add   = 1'b0;
    take_last  = 1'b0;
    seq_hit    = 1'b0;
    if (beat) begin
      case (state_reg)
        IDLE: begin
          if (f_a) begin
            take_first = 1'b1;
            take_last  = l_a;
          end else begin
            seq_hit    = 1'b1;
          end
        end
        ACCUM: begin
          take_first = f_a;
          take_add   = ~f_a;
          seq_hit    = f_a;
          take_last  = l_a;
        end
        default: ;
      endcase
    end
  end

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod[PROD_WIDTH-1]}}, bus.prod};
  assign sum_wide = {acc_reg[ACC_WIDTH-1], acc_reg} + {prod_ext[ACC_WIDTH-1], prod_ext};
  assign acc_clamp = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

  always_comb begin
    sum_sat = sum_wide[ACC_WIDTH-1:0];
    if (acc_clamp) sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  assign acc_next = take_first ? prod_ext : sum_sat;

  // One guard bit keeps the rounding add from wrapping at the accumulator limits.
  assign rnd_wide  = {acc_next[ACC_WIDTH-1], acc_next} + RND_HALF;
  assign rnd_shift = rnd_wide >>> SHIFT;
  assign out_hi    = rnd_shift > OUT_MAX_W;
  assign out_lo    = rnd_shift < OUT_MIN_W;

  always_comb begin
    result_next = rnd_shift[OUT_WIDTH-1:0];
    if (out_hi)      result_next = OUT_MAX;
    else if (out_lo) result_next = OUT_MIN;
  end

  assign len_hit = take_add && (cnt_reg >= CNT_W'(MAX_TERMS));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      if (take_first || take_add) acc_reg <= acc_next;
      if (take_first)
        cnt_reg <= CNT_W'(1);
      else if (take_add && cnt_reg != CNT_W'(MAX_TERMS + 1))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A fresh result always wins the output register; the handshake only clears valid when nothing loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      seq_err_reg   <= 1'b0;
      len_err_reg   <= 1'b0;
      ovr_err_reg   <= 1'b0;
    end else begin
      if (take_last) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= result_next;
        if (out_valid_reg && !bus.out_ready) ovr_err_reg <= 1'b1;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (seq_hit) seq_err_reg <= 1'b1;
      if (len_hit) len_err_reg <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.seq_err   = seq_err_reg;
  assign bus.len_err   = len_err_reg;
  assign bus.ovr_err   = ovr_err_reg;

`ifdef MPC_MAC_SAT_CNT_EN
  logic [15:0] sat_count_reg;
  logic [1:0]  sat_inc;
  logic [16:0] sat_sum;

  // Accumulator clamp and output clamp on the same beat count separately.
  assign sat_inc = {1'b0, take_add & acc_clamp} + {1'b0, take_last & (out_hi | out_lo)};
  assign sat_sum = {1'b0, sat_count_reg} + {15'd0, sat_inc};

  always_ff @(posedge clk) begin
    if (reset)            sat_count_reg <= '0;
    else if (sat_sum[16]) sat_count_reg <= 16'hFFFF;
    else                  sat_count_reg <= sat_sum[15:0];
  end

  assign bus.sat_count = sat_count_reg;
`else
  assign bus.sat_count = 16'd0;
`endif
endmodule

// File: tb/tb_mpc_mac_acc_sat.sv
// Scoreboard bench for mpc_mac_acc_sat: directed frames plus randomized frames against a plain-arithmetic frame model.
`timescale 1ns/1ps
module tb_mpc_mac_acc_sat;
  localparam int L  = 3;
  localparam int PW = 35;
  localparam int AW = 40;
  localparam int SH = 13;
  localparam int OW = 21;
  localparam int MT = 32;
  localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (AW - 1));
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));

  typedef struct {
    longint data;
    longint due;
    bit     chk_time;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  logic   ce;
  longint ce_edges = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  exp_t   exp_q[$];
  longint mp[L];
  bit     last_ce, last_v;
  longint last_p;
  int     ce_pct;
  bit     hold_mode;

  bit     m_in_frame, m_seq, m_len, m_ovr;
  longint m_acc;
  int     m_cnt, m_sat;

  mpc_mac_acc_sat_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

  mpc_mac_acc_sat #(
    .MUL_LATENCY(L), .PROD_WIDTH(PW), .ACC_WIDTH(AW),
    .SHIFT(SH), .OUT_WIDTH(OW), .MAX_TERMS(MT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ce) ce_edges <= ce_edges + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%0d req=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic longint exp_sat_count();
`ifdef MPC_MAC_SAT_CNT_EN
    return (m_sat > 65535) ? 65535 : longint'(m_sat);
`else
    return 0;
`endif
  endfunction

  // Frame rules applied at issue time; results queue in issue order.
  function automatic void model_beat(bit f, bit l, longint p);
    exp_t   e;
    longint r;
    if (!m_in_frame && !f) begin
      m_seq = 1'b1;
      return;
    end
    if (m_in_frame && f) m_seq = 1'b1;
    if (f) begin
      m_acc = p;
      m_cnt = 1;
    end else begin
      m_acc = m_acc + p;
      m_cnt++;
      if (m_acc > AMAX) begin m_acc = AMAX; m_sat++; end
      else if (m_acc < AMIN) begin m_acc = AMIN; m_sat++; end
      if (m_cnt > MT) m_len = 1'b1;
    end
    m_in_frame = 1'b1;
    if (l) begin
      m_in_frame = 1'b0;
      r = (m_acc + (64'sd1 <<< (SH - 1))) >>> SH;
      if (r > OMAX) begin r = OMAX; m_sat++; end
      else if (r < OMIN) begin r = OMIN; m_sat++; end
      e.data     = r;
      e.due      = ce_edges + 1 + L;
      e.chk_time = !hold_mode;
      if (hold_mode && exp_q.size() != 0) begin
        m_ovr = 1'b1;
        exp_q.delete();
      end
      exp_q.push_back(e);
    end
  endfunction

  // One clock: the multiplier stand-in advances on ce; ce-low cycles carry junk the DUT must ignore.
  task automatic step(input bit c, input bit v, input bit f, input bit l, input longint p);
    longint r64;
    @(posedge clk);
    #1;
    if (last_ce) begin
      for (int i = L - 1; i > 0; i--) mp[i] = mp[i-1];
      mp[0] = last_v ? last_p : 0;
    end
    ce = c;
    r64 = longint'({$urandom(), $urandom()});
    if (c) begin
      bus.in_valid = v;
      bus.in_first = v ? f : 1'($urandom);
      bus.in_last  = v ? l : 1'($urandom);
      bus.prod     = PW'(mp[L-1]);
      if (v) model_beat(f, l, p);
    end else begin
      bus.in_valid = 1'($urandom);
      bus.in_first = 1'($urandom);
      bus.in_last  = 1'($urandom);
      bus.prod     = PW'(r64);
    end
    last_ce = c;
    last_v  = c & v;
    last_p  = p;
  endtask

  task automatic beat(input bit f, input bit l, input longint p);
    while (32'($urandom_range(99)) >= ce_pct) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, f, l, p);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_flags(input string tag);
    idle(L + 3);
    chk({tag, "_seq_err"}, longint'(bus.seq_err), longint'(m_seq));
    chk({tag, "_len_err"}, longint'(bus.len_err), longint'(m_len));
    chk({tag, "_ovr_err"}, longint'(bus.ovr_err), longint'(m_ovr));
    chk({tag, "_sat_count"}, longint'(bus.sat_count), exp_sat_count());
    chk({tag, "_pending"}, longint'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ce = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.prod     = '0;
    for (int i = 0; i < L; i++) mp[i] = 0;
    last_ce = 1'b0; last_v = 1'b0; last_p = 0;
    m_in_frame = 1'b0; m_seq = 1'b0; m_len = 1'b0; m_ovr = 1'b0;
    m_acc = 0; m_cnt = 0; m_sat = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_errs", longint'({bus.seq_err, bus.len_err, bus.ovr_err}), 0);
    chk("rst_sat_count", longint'(bus.sat_count), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_result act=%0d req=none t=%0t", bus.out_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] result out_data=%0d expected=%0d ce_edge=%0d", bus.out_data, e.data, ce_edges);
        chk("out_data", longint'(bus.out_data), e.data);
        if (e.chk_time) chk("latency_ce_edges", ce_edges, e.due);
      end
    end
  end

  initial begin
    longint r64, p;
    int     n;
    bit     f;
    reset = 1'b1;
    ce = 1'b0;
    bus.out_ready = 1'b1;
    ce_pct = 100;
    hold_mode = 1'b0;
    do_reset();

    // 4 x 1.0 -> 4, four ce-cycles after the last operand
    beat(1, 0, 8192); beat(0, 0, 8192); beat(0, 0, 8192); beat(0, 1, 8192);
    check_flags("four_term");

    // ce held low for two cycles mid-frame
    beat(1, 0, 8192); beat(0, 0, 8192);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0); step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    beat(0, 0, 8192); beat(0, 1, 8192);
    check_flags("ce_stall");

    // one-term frames around the rounding midpoint
    beat(1, 1, -4097);
    beat(1, 1, 4096);
    check_flags("one_term");

    // output saturation
    beat(1, 0, 64'sd1 <<< 33); beat(0, 1, 64'sd1 <<< 33);
    check_flags("out_sat");

    // overwrite while stalled: second result replaces the first
    bus.out_ready = 1'b0;
    hold_mode = 1'b1;
    beat(1, 0, 100 * 8192); beat(0, 1, 0);
    beat(1, 1, 7 * 8192);
    idle(L + 3);
    chk("hold_valid", longint'(bus.out_valid), 1);
    chk("hold_data", longint'(bus.out_data), 7);
    chk("hold_ovr_err", longint'(bus.ovr_err), 1);
    idle(3);
    chk("hold_stable", longint'(bus.out_data), 7);
    bus.out_ready = 1'b1;
    hold_mode = 1'b0;
    check_flags("overwrite");

    // beat without first while idle is dropped
    beat(0, 0, 5 * 8192);
    beat(1, 1, 3 * 8192);
    check_flags("seq_idle");

    // reset mid-frame discards the partial sum
    beat(1, 0, 64'sd1 <<< 30); beat(0, 0, 64'sd1 <<< 30);
    do_reset();
    beat(1, 1, 9 * 8192);
    check_flags("reset_mid");

    // 32 terms is legal; 33 terms of max product sets len_err and clamps
    for (int k = 0; k < MT; k++) beat(k == 0, k == MT - 1, 8192);
    check_flags("len_32");
    for (int k = 0; k <= MT; k++) beat(k == 0, k == MT, (64'sd1 <<< 34) - 1);
    check_flags("len_33");

    // randomized frames with ce gaps and occasional framing faults
    ce_pct = 75;
    for (int fr = 0; fr < 60; fr++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        if (k == 0) f = ($urandom_range(19) != 0);
        else        f = ($urandom_range(29) == 0);
        r64 = longint'({$urandom(), $urandom()});
        if ($urandom_range(1) == 0) p = r64 >>> (64 - PW);
        else                        p = longint'($urandom_range(40000)) - 20000;
        beat(f, k == n - 1, p);
      end
      idle($urandom_range(0, 2));
    end
    ce_pct = 100;
    check_flags("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
